// File: rtl/pc_ctrl.sv
// Fetch PC / redirect controller: advances the PC, redirects on taken branch or jump,
// and holds o_flush for FLUSH_CYCLES unstalled cycles. Optional: PC_CTRL_MISALIGN_TRAP_EN.
module pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_branch,
  input  logic            i_take,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc,
  output logic            o_flush,
  output logic            o_redirect,
  output logic            o_misalign
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;

  logic            req;
  logic            bad_tgt;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_inc;

  assign req    = (i_branch & i_take) | i_jump;
  assign pc_inc = pc_q + XLEN'(4);
  assign tgt    = i_target & ~XLEN'(3);

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  assign bad_tgt = |i_target[1:0];
`else
  assign bad_tgt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    // A latched misalign trap freezes the whole controller until reset.
    if (!misalign_q) begin
      case (state_q)
        RUN: begin
          if (req) begin
            if (bad_tgt) begin
              misalign_d = 1'b1;
            end else begin
              pc_d       = tgt;
              redirect_d = 1'b1;
              state_d    = FLUSH;
              cnt_d      = CNT_INIT;
            end
          end else if (!i_stall) begin
            pc_d = pc_inc;
          end
        end
        FLUSH: begin
          // EX holds a wrong-path instruction here, so req is ignored.
          if (!i_stall) begin
            pc_d = pc_inc;
            if (cnt_q == 3'd0) state_d = RUN;
            else               cnt_d   = cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_flush    = (state_q == FLUSH);
  assign o_redirect = redirect_q;
  assign o_misalign = misalign_q;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and redirect controller for the cotm32 core, directly downstream of the branch unit. Consumes the branch unit's `o_take` together with the EX-stage branch/jump flags and target address. Maintains the fetch PC, redirects fetch on a taken branch or jump, and drives a multi-cycle flush of the IF/ID stages so wrong-path instructions are killed. Handles fetch stalls and the post-redirect flush window.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `FLUSH_CYCLES`, default `2`: number of cycles `o_flush` is held after a redirect. Legal range is 1..7.

Ports:
- `i_clk`  in  1  Clock. Single clock domain; all state updates on the rising edge.
- `i_rst`  in  1  Reset. Synchronous, active-high.
- `i_stall`  in  1  Fetch stall. Holds the PC and freezes the flush counter.
- `i_branch`  in  1  EX holds a valid conditional branch.
- `i_take`  in  1  Branch-unit decision (`o_take`). Only meaningful when `i_branch` is 1.
- `i_jump`  in  1  EX holds a valid unconditional jump (JAL/JALR).
- `i_target`  in  `XLEN`  Redirect target address from EX.
- `o_pc`  out  `XLEN`  Current fetch address (registered).
- `o_flush`  out  1  Kill IF/ID contents (registered).
- `o_redirect`  out  1  One-cycle pulse: the PC was redirected on the previous edge.
- `o_misalign`  out  1  Sticky misaligned-target flag. Present only when the macro in Configuration is defined; otherwise tied to 0.

## Operation

- Redirect request: `req = (i_branch & i_take) | i_jump`.
- FSM with two states, `RUN` and `FLUSH`, plus a 3-bit counter `cnt`.
- In `RUN`:
  - If `req`: `o_pc <= tgt`, `o_redirect <= 1`, go to `FLUSH`, `cnt <= FLUSH_CYCLES-1`.
  - Else if `!i_stall`: `o_pc <= o_pc + 4`.
  - Else: hold.
  - A redirect has priority over a stall.
- In `FLUSH`:
  - `req` is ignored, because the EX instruction is wrong-path.
  - If `!i_stall`: `o_pc <= o_pc + 4`.
  - If `cnt == 0`: return to `RUN`; otherwise `cnt <= cnt-1`.
  - If `i_stall`: the PC, `cnt` and the state all hold.
- `o_flush` is 1 exactly while the state is `FLUSH`.
- `o_redirect` is 1 only in the cycle following a redirect edge.
- PC arithmetic is modulo 2^32. `32'hFFFF_FFFC + 4` wraps to `32'h0000_0000`.
- `tgt` is `i_target` with bits [1:0] cleared. This applies when the macro is not defined.

## Timing

- Reset values:
  - `o_pc = RESET_PC`
  - `o_flush = 0`
  - `o_redirect = 0`
  - `o_misalign = 0`
  - state = `RUN`, `cnt = 0`
- `i_rst` overrides everything, including reset asserted mid-`FLUSH`.
- Redirect latency: `req` sampled at edge N gives `o_pc = tgt` after edge N. `o_flush` is high for `FLUSH_CYCLES` unstalled cycles starting after edge N.
- Back-to-back: a `req` in the first `RUN` cycle after a flush is honoured.
- There is no combinational path from inputs to outputs.

## Configuration

- `PC_CTRL_MISALIGN_TRAP_EN` defined:
  - A `req` with `i_target[1:0] != 0` does not redirect.
  - `o_misalign` sets on the next edge and stays set until reset.
  - While `o_misalign` is 1, the PC holds and all further `req` are ignored.
  - `o_redirect` and `o_flush` are not asserted for that request.
- `PC_CTRL_MISALIGN_TRAP_EN` undefined:
  - Target bits [1:0] are silently cleared.
  - `o_misalign` is constant 0.

## Test plan

- Reset with `RESET_PC=32'h100`, then 3 cycles with no stall and no `req` -> `o_pc` goes 100, 104, 108, 10C; `o_flush=0`.
- `i_branch=1, i_take=1, i_target=32'h200` for one cycle, `FLUSH_CYCLES=2` -> next cycle `o_pc=200`, `o_redirect=1`. `o_flush=1` for exactly 2 cycles while `o_pc` advances to 204, 208.
- `i_branch=1, i_take=0` -> no redirect, PC increments. `i_jump=1` with a `req` arriving during `FLUSH` -> ignored, PC unaffected.
- `i_stall=1` for 3 cycles mid-`FLUSH` -> `o_pc` and `o_flush` hold. The flush finishes after the stall with the total flushed unstalled cycles equal to 2.
- `o_pc=32'hFFFF_FFFC`, no `req` -> next `o_pc=0`. `i_rst` asserted during `FLUSH` -> next cycle `o_pc=RESET_PC`, `o_flush=0`.
- With the macro, `i_jump=1, i_target=32'h202` -> `o_misalign=1` and stays 1, `o_pc` frozen, `o_redirect=0`. Without the macro, the same stimulus -> `o_pc=200`.
